// File: rtl/cpu_params.sv
// Core-wide sizing constants for the out-of-order backend.
package cpu_params;
  localparam int ROB_DEPTH     = 32;
  localparam int ROB_IDX_WIDTH = $clog2(ROB_DEPTH);
  localparam int PRF_IDX_WIDTH = 6;
  localparam int ARF_IDX_WIDTH = 5;
  localparam int CDB_WIDTH     = 2;
endpackage

// File: rtl/uop_types.sv
// Shared micro-op bookkeeping types.
package uop_types;
  import cpu_params::*;

  typedef struct packed {
    logic                     valid;
    logic                     done;
    logic [PRF_IDX_WIDTH-1:0] rd_phy;
    logic [ARF_IDX_WIDTH-1:0] rd_arch;
  } rob_entry_t;
endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order completion via CDB ports,
// in-order single-wide retirement.
module rob
  import uop_types::rob_entry_t;
#(
  parameter int ROB_DEPTH = cpu_params::ROB_DEPTH,
  parameter int CDB_WIDTH = cpu_params::CDB_WIDTH,
  localparam int IW = $clog2(ROB_DEPTH),
  localparam int PW = cpu_params::PRF_IDX_WIDTH,
  localparam int AW = cpu_params::ARF_IDX_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dispatch_valid,
  output logic                          dispatch_ready,
  input  logic [PW-1:0]                 dispatch_rd_phy,
  input  logic [AW-1:0]                 dispatch_rd_arch,
  output logic [IW-1:0]                 dispatch_rob_id,
  input  logic [CDB_WIDTH-1:0]          cdb_valid,
  input  logic [CDB_WIDTH-1:0][IW-1:0]  cdb_rob_id,
  output logic                          commit_valid,
  output logic [IW-1:0]                 commit_rob_id,
  output logic [PW-1:0]                 commit_rd_phy,
  output logic [AW-1:0]                 commit_rd_arch,
  output logic [IW:0]                   rob_count
);

  rob_entry_t [ROB_DEPTH-1:0] ent_q, ent_d;
  logic [IW:0] head_q, head_d, tail_q, tail_d;
  logic        full;
  rob_entry_t  head_ent;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign full            = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
  assign dispatch_ready  = !full;
  assign dispatch_rob_id = tail_q[IW-1:0];
  assign rob_count       = tail_q - head_q;

  assign head_ent       = ent_q[head_q[IW-1:0]];
  assign commit_valid   = head_ent.valid && head_ent.done;
  assign commit_rob_id  = head_q[IW-1:0];
  assign commit_rd_phy  = head_ent.rd_phy;
  assign commit_rd_arch = head_ent.rd_arch;

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    // Completion is qualified by the registered valid bit, so a CDB write
    // never marks a slot that is being allocated this same cycle.
    for (int p = 0; p < CDB_WIDTH; p++) begin
      if (cdb_valid[p] && ent_q[cdb_rob_id[p]].valid)
        ent_d[cdb_rob_id[p]].done = 1'b1;
    end
    if (commit_valid) begin
      ent_d[head_q[IW-1:0]].valid = 1'b0;
      ent_d[head_q[IW-1:0]].done  = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (dispatch_valid && dispatch_ready) begin
      ent_d[tail_q[IW-1:0]].valid   = 1'b1;
      ent_d[tail_q[IW-1:0]].done    = 1'b0;
      ent_d[tail_q[IW-1:0]].rd_phy  = dispatch_rd_phy;
      ent_d[tail_q[IW-1:0]].rd_arch = dispatch_rd_arch;
      tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter ROB_DEPTH, default 32, number of entries; power of two.
REQ-002 Parameter CDB_WIDTH, default 2, number of writeback broadcast ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 dispatch_valid  input  1  decode/rename presents one uop for allocation.
REQ-006 dispatch_ready  output  1  ROB can allocate this cycle.
REQ-007 dispatch_rd_phy  input  6  destination physical register.
REQ-008 dispatch_rd_arch  input  5  destination architectural register.
REQ-009 dispatch_rob_id  output  log2(ROB_DEPTH)  index allocated to the presented uop (current tail).
REQ-010 cdb_valid  input  CDB_WIDTH  per-port writeback valid.
REQ-011 cdb_rob_id  input  CDB_WIDTH x log2(ROB_DEPTH)  per-port completing ROB index.
REQ-012 commit_valid  output  1  head entry retires this cycle.
REQ-013 commit_rob_id  output  log2(ROB_DEPTH)  retiring index.
REQ-014 commit_rd_phy  output  6  retiring physical destination, to RRF/free list.
REQ-015 commit_rd_arch  output  5  retiring architectural destination.
REQ-016 rob_count  output  log2(ROB_DEPTH)+1  current occupancy.

Function
REQ-017 The ROB SHALL be a circular buffer with head/tail pointers of log2(ROB_DEPTH)+1 bits (index plus wrap bit).
REQ-018 Each entry SHALL hold valid, done, rd_phy, rd_arch.
REQ-019 Full SHALL be index equal and wrap bit different; empty SHALL be pointers equal.
REQ-020 dispatch_ready SHALL equal not-full, registered state only; no same-cycle commit pass-through.
REQ-021 dispatch_rob_id SHALL equal tail index, combinationally, regardless of dispatch_valid.
REQ-022 On dispatch_valid and dispatch_ready, the entry at tail SHALL be written valid=1, done=0, rd_phy, rd_arch, and tail SHALL increment, wrapping to 0 with wrap-bit toggle.
REQ-023 For each port with cdb_valid, done SHALL be set at cdb_rob_id if that entry is valid; writes to invalid entries SHALL be ignored.
REQ-024 Multiple CDB ports targeting distinct or identical indices in one cycle SHALL all take effect.
REQ-025 commit_valid SHALL be combinational: head entry valid and done; commit_* SHALL present head entry fields.
REQ-026 Commit SHALL be unconditional (consumer always accepts); on commit_valid, head entry valid SHALL clear and head SHALL increment at the edge.
REQ-027 At most one commit per cycle, strictly in order.
REQ-028 No CDB-to-commit bypass: CDB at edge N yields commit_valid no earlier than cycle N+1; dispatch at N allows commit no earlier than N+2.
REQ-029 Simultaneous dispatch and commit SHALL leave rob_count unchanged; rob_count SHALL be tail minus head.
REQ-030 Commit and dispatch in the same cycle to the same index (full-to-drain) SHALL not occur since dispatch_ready=0 when full.

Reset
REQ-031 rst low SHALL immediately, without a clock edge, clear all valid/done bits, head=tail=0.
REQ-032 During reset: dispatch_ready=1, dispatch_rob_id=0, commit_valid=0, rob_count=0; rd fields of entries need not reset.
REQ-033 Reset mid-operation SHALL discard all in-flight entries; first dispatch after release SHALL receive rob_id 0.

Structure
REQ-034 ROB_DEPTH, ROB_IDX_WIDTH, PRF_IDX_WIDTH, ARF_IDX_WIDTH, CDB_WIDTH SHALL live in cpu_params.
REQ-035 Entry struct rob_entry_t (valid, done, rd_phy, rd_arch) SHALL live in uop_types.
REQ-036 Single module, no sub-module.

Verification
REQ-037 Reset: rst low then high -> dispatch_ready=1, dispatch_rob_id=0, commit_valid=0, rob_count=0.
REQ-038 Single uop: dispatch rd_phy=1 rd_arch=1 at cycle 0 -> rob_id 0; CDB port0 rob_id 0 at cycle 2 -> commit_valid at cycle 3 with rd_phy=1, rd_arch=1; rob_count returns to 0.
REQ-039 Out-of-order completion: dispatch ids 0-3; CDB 3,2,1 -> no commit; CDB 0 -> commits 0,1,2,3 on four consecutive cycles.
REQ-040 Full/wrap: 32 dispatches, no CDB -> rob_count=32, dispatch_ready=0, 33rd held; CDB id 0 -> commit id 0, next cycle dispatch_ready=1, held uop gets rob_id 0.
REQ-041 Dual CDB: ports 0 and 1 complete ids 1 and 0 in the same cycle -> commits id 0 then id 1 on consecutive cycles.
REQ-042 Async reset: 5 entries in flight, rst asserted between edges -> commit_valid=0, rob_count=0 before next edge.
